// File: rtl/vec_issue_controller.sv
// ---------------------------------------------------------------------------
// vec_issue_controller
//
// Registered instruction-issue controller for the vector processor.
// Instructions are accepted from fetch over a valid/ready handshake and
// issued one cycle later as decoded datapath control lines. Vector memory
// ops (LW_V / SW_V) expand into VLEN consecutive beats with an element
// index. BEQ is issued for a single beat, after which issue stalls until
// the branch resolves. A taken branch then raises flush for BR_FLUSH cycles.
//
// Parameters
//   VLEN      elements per vector memory op (>= 1)
//   BR_FLUSH  flush cycles after a taken branch (>= 0)
//
// Ports
//   clk, rst          clock and synchronous active-high reset
//   instn             instruction word; opcode is instn[31:26]
//   instn_valid       fetch offers instn
//   instn_ready       controller accepts this cycle (combinational)
//   br_resolved       branch outcome valid this cycle
//   PCSrc             branch taken; qualified by br_resolved
//   opcode            opcode of the issued instruction
//   ctrl_valid        control lines describe a real issue beat
//   RegDst .. ALUOp   decoded datapath controls, zero when ctrl_valid=0
//   elem_idx          element index of the current vector beat
//   last_elem         final beat of an instruction
//   illegal           issued opcode is not a known instruction
//   beq_enable        high while waiting on or flushing after a branch
//   flush             fetch/pipeline flush request
// ---------------------------------------------------------------------------
module vec_issue_controller #(
  parameter int VLEN     = 4,
  parameter int BR_FLUSH = 2,
  localparam int IW      = (VLEN > 1) ? $clog2(VLEN) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   instn,
  input  logic          instn_valid,
  output logic          instn_ready,
  input  logic          br_resolved,
  input  logic          PCSrc,
  output logic [5:0]    opcode,
  output logic          ctrl_valid,
  output logic          RegDst,
  output logic          ALUSrc,
  output logic          branch,
  output logic          MemWrite,
  output logic          RegWrite,
  output logic          MemtoReg,
  output logic [1:0]    ALUOp,
  output logic [IW-1:0] elem_idx,
  output logic          last_elem,
  output logic          illegal,
  output logic          beq_enable,
  output logic          flush
);

  // Project opcode set.
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SET   = 6'b001111;
  localparam logic [5:0] OP_LW_R  = 6'b100100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW_R  = 6'b101100;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_LW_V  = 6'b110011;
  localparam logic [5:0] OP_SW_V  = 6'b111011;

  localparam int           CW       = (BR_FLUSH > 0) ? $clog2(BR_FLUSH + 1) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(VLEN - 1);
  localparam logic [CW-1:0] FLUSH_LEN = CW'(BR_FLUSH);

  typedef enum logic [1:0] {
    S_NORMAL,
    S_VEC,
    S_BR_WAIT,
    S_FLUSH
  } state_t;

  state_t        state_reg;
  logic [5:0]    ir_reg;          // only the opcode field is used downstream
  logic [CW-1:0] cnt_reg;
  logic          ctrl_valid_reg;
  logic [IW-1:0] elem_idx_reg;

  logic [5:0]    in_op;
  logic          in_vec;
  logic          accept;
  logic          at_last_idx;
  state_t        accept_state;
  logic [7:0]    dec;             // {RegDst, ALUOp, ALUSrc, branch, MemWrite, RegWrite, MemtoReg}
  logic          dec_illegal;
  logic          ir_vec;
  logic          unused_instn_bits;

  assign unused_instn_bits = ^instn[25:0];

  assign in_op       = instn[31:26];
  assign in_vec      = (in_op == OP_LW_V) || (in_op == OP_SW_V);
  assign at_last_idx = (elem_idx_reg == LAST_IDX);
  assign ir_vec      = (ir_reg == OP_LW_V) || (ir_reg == OP_SW_V);

  // Ready is a function of registered state only, so fetch never sees a
  // combinational path from its own valid back to ready.
  always_comb begin
    instn_ready = 1'b0;
    case (state_reg)
      S_NORMAL: instn_ready = 1'b1;
      S_VEC:    instn_ready = at_last_idx;
      default:  instn_ready = 1'b0;
    endcase
  end

  assign accept = instn_valid && instn_ready;

  // Where an accepted instruction goes next. A one-element vector op is
  // indistinguishable from a scalar op, so it stays in NORMAL.
  always_comb begin
    accept_state = S_NORMAL;
    if (in_vec && (VLEN > 1))
      accept_state = S_VEC;
    else if (in_op == OP_BEQ)
      accept_state = S_BR_WAIT;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= S_NORMAL;
      ir_reg         <= '0;
      cnt_reg        <= '0;
      ctrl_valid_reg <= 1'b0;
      elem_idx_reg   <= '0;
    end else begin
      case (state_reg)
        S_NORMAL: begin
          if (accept) begin
            ir_reg         <= in_op;
            ctrl_valid_reg <= 1'b1;
            elem_idx_reg   <= '0;
            state_reg      <= accept_state;
          end else begin
            ctrl_valid_reg <= 1'b0;
          end
        end
        S_VEC: begin
          if (!at_last_idx) begin
            elem_idx_reg <= elem_idx_reg + IW'(1);
          end else if (accept) begin
            // Last beat overlaps the next accept: no bubble between ops.
            ir_reg         <= in_op;
            ctrl_valid_reg <= 1'b1;
            elem_idx_reg   <= '0;
            state_reg      <= accept_state;
          end else begin
            ctrl_valid_reg <= 1'b0;
            state_reg      <= S_NORMAL;
          end
        end
        S_BR_WAIT: begin
          ctrl_valid_reg <= 1'b0;
          if (br_resolved) begin
            if (PCSrc && (BR_FLUSH > 0)) begin
              cnt_reg   <= FLUSH_LEN;
              state_reg <= S_FLUSH;
            end else begin
              state_reg <= S_NORMAL;
            end
          end
        end
        S_FLUSH: begin
          cnt_reg <= cnt_reg - CW'(1);
          if (cnt_reg <= CW'(1))
            state_reg <= S_NORMAL;
        end
        default: state_reg <= S_NORMAL;
      endcase
    end
  end

  // Opcode decode of the issued instruction.
  always_comb begin
    dec         = 8'b0;
    dec_illegal = 1'b0;
    case (ir_reg)
      OP_RTYPE:         dec = 8'b1_10_0_0_0_1_0;
      OP_LW:            dec = 8'b0_10_1_0_0_1_1;
      OP_SW:            dec = 8'b0_00_1_0_1_0_0;
      OP_LW_R, OP_LW_V: dec = 8'b1_10_0_0_0_1_1;
      OP_SW_R, OP_SW_V: dec = 8'b1_10_0_0_1_0_0;
      OP_BEQ:           dec = 8'b0_01_0_1_0_0_0;
      OP_ADDI, OP_SET:  dec = 8'b0_00_1_0_0_1_0;
      default:          dec_illegal = 1'b1;
    endcase
  end

  assign opcode     = ir_reg;
  assign ctrl_valid = ctrl_valid_reg;
  assign elem_idx   = elem_idx_reg;
  assign RegDst     = ctrl_valid_reg & dec[7];
  assign ALUOp      = ctrl_valid_reg ? dec[6:5] : 2'b00;
  assign ALUSrc     = ctrl_valid_reg & dec[4];
  assign branch     = ctrl_valid_reg & dec[3];
  assign MemWrite   = ctrl_valid_reg & dec[2];
  assign RegWrite   = ctrl_valid_reg & dec[1];
  assign MemtoReg   = ctrl_valid_reg & dec[0];
  assign illegal    = ctrl_valid_reg & dec_illegal;
  // Scalar beats are always their own last beat.
  assign last_elem  = ctrl_valid_reg & (!ir_vec || at_last_idx);
  assign beq_enable = (state_reg == S_BR_WAIT) || (state_reg == S_FLUSH);
  assign flush      = (state_reg == S_FLUSH);

endmodule

// File: tb/tb_vec_issue_controller.sv
// ---------------------------------------------------------------------------
// tb_vec_issue_controller
//
// Directed bench for vec_issue_controller. Two instances share stimulus:
// dut uses VLEN=4, BR_FLUSH=2 and dz uses VLEN=4, BR_FLUSH=0. Inputs change
// and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_vec_issue_controller;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_LW_V  = 6'b110011;
  localparam logic [5:0] OP_SW_V  = 6'b111011;
  localparam logic [5:0] OP_BAD   = 6'b111111;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instn;
  logic        instn_valid;
  logic        br_resolved;
  logic        PCSrc;

  logic       instn_ready, ctrl_valid, RegDst, ALUSrc, branch, MemWrite, RegWrite, MemtoReg;
  logic [1:0] ALUOp;
  logic [5:0] opcode;
  logic [1:0] elem_idx;
  logic       last_elem, illegal, beq_enable, flush;

  logic       z_instn_ready, z_ctrl_valid, z_RegDst, z_ALUSrc, z_branch, z_MemWrite, z_RegWrite, z_MemtoReg;
  logic [1:0] z_ALUOp;
  logic [5:0] z_opcode;
  logic [1:0] z_elem_idx;
  logic       z_last_elem, z_illegal, z_beq_enable, z_flush;

  logic [7:0] ctrl;
  assign ctrl = {RegDst, ALUOp, ALUSrc, branch, MemWrite, RegWrite, MemtoReg};

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  vec_issue_controller #(.VLEN(4), .BR_FLUSH(2)) dut (
    .clk(clk), .rst(rst), .instn(instn), .instn_valid(instn_valid),
    .instn_ready(instn_ready), .br_resolved(br_resolved), .PCSrc(PCSrc),
    .opcode(opcode), .ctrl_valid(ctrl_valid), .RegDst(RegDst), .ALUSrc(ALUSrc),
    .branch(branch), .MemWrite(MemWrite), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
    .ALUOp(ALUOp), .elem_idx(elem_idx), .last_elem(last_elem), .illegal(illegal),
    .beq_enable(beq_enable), .flush(flush)
  );

  vec_issue_controller #(.VLEN(4), .BR_FLUSH(0)) dz (
    .clk(clk), .rst(rst), .instn(instn), .instn_valid(instn_valid),
    .instn_ready(z_instn_ready), .br_resolved(br_resolved), .PCSrc(PCSrc),
    .opcode(z_opcode), .ctrl_valid(z_ctrl_valid), .RegDst(z_RegDst), .ALUSrc(z_ALUSrc),
    .branch(z_branch), .MemWrite(z_MemWrite), .RegWrite(z_RegWrite), .MemtoReg(z_MemtoReg),
    .ALUOp(z_ALUOp), .elem_idx(z_elem_idx), .last_elem(z_last_elem), .illegal(z_illegal),
    .beq_enable(z_beq_enable), .flush(z_flush)
  );

  task automatic offer(input logic [5:0] op);
    instn       = {op, 26'h0_5A5A5};
    instn_valid = 1'b1;
  endtask

  task automatic idle();
    instn_valid = 1'b0;
    instn       = 32'h0;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle(); br_resolved = 1'b0; PCSrc = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    vectors++; if (instn_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got=%b exp=1", instn_ready); end
    vectors++; if (ctrl_valid !== 1'b0) begin miscompares++; $display("FAIL reset_ctrl_valid got=%b exp=0", ctrl_valid); end
    vectors++; if (flush !== 1'b0 || beq_enable !== 1'b0) begin miscompares++; $display("FAIL reset_flush got=%b/%b exp=0/0", flush, beq_enable); end
    vectors++; if (RegWrite !== 1'b0 || ctrl !== 8'h00) begin miscompares++; $display("FAIL reset_ctrl got=%b exp=00000000", ctrl); end
    $display("reset: ready=%b ctrl_valid=%b flush=%b", instn_ready, ctrl_valid, flush);
  endtask

  task automatic test_scalar();
    offer(OP_ADDI);
    @(negedge clk);
    offer(OP_SW);
    vectors++; if (ctrl_valid !== 1'b1 || opcode !== OP_ADDI) begin miscompares++; $display("FAIL addi_issue got=%b/%h exp=1/%h", ctrl_valid, opcode, OP_ADDI); end
    vectors++; if (ctrl !== 8'b0_00_1_0_0_1_0) begin miscompares++; $display("FAIL addi_ctrl got=%b exp=00010010", ctrl); end
    vectors++; if (last_elem !== 1'b1 || elem_idx !== 2'd0) begin miscompares++; $display("FAIL addi_last got=%b/%0d exp=1/0", last_elem, elem_idx); end
    $display("scalar ADDI: ctrl=%b last=%b", ctrl, last_elem);
    @(negedge clk);
    idle();
    vectors++; if (ctrl_valid !== 1'b1 || opcode !== OP_SW || ctrl !== 8'b0_00_1_0_1_0_0) begin miscompares++; $display("FAIL sw_back_to_back got=%b/%h/%b exp=1/%h/00010100", ctrl_valid, opcode, ctrl, OP_SW); end
    $display("scalar SW: ctrl=%b", ctrl);
    @(negedge clk);
    vectors++; if (ctrl_valid !== 1'b0 || ctrl !== 8'h00 || last_elem !== 1'b0) begin miscompares++; $display("FAIL idle_gating got=%b/%b/%b exp=0/00000000/0", ctrl_valid, ctrl, last_elem); end
    vectors++; if (opcode !== OP_SW) begin miscompares++; $display("FAIL idle_opcode got=%h exp=%h", opcode, OP_SW); end
    $display("idle: ctrl_valid=%b opcode=%h", ctrl_valid, opcode);
  endtask

  task automatic test_vector();
    offer(OP_LW_V);
    @(negedge clk);
    offer(OP_RTYPE);
    for (int i = 0; i < 4; i++) begin
      vectors++; if (ctrl_valid !== 1'b1 || elem_idx !== 2'(i)) begin miscompares++; $display("FAIL lwv_beat%0d got=%b/%0d exp=1/%0d", i, ctrl_valid, elem_idx, i); end
      vectors++; if (ctrl !== 8'b1_10_0_0_0_1_1) begin miscompares++; $display("FAIL lwv_ctrl%0d got=%b exp=11000011", i, ctrl); end
      vectors++; if (last_elem !== (i == 3) || instn_ready !== (i == 3)) begin miscompares++; $display("FAIL lwv_last%0d got=%b/%b exp=%b/%b", i, last_elem, instn_ready, i == 3, i == 3); end
      $display("LW_V beat: idx=%0d last=%b ready=%b", elem_idx, last_elem, instn_ready);
      @(negedge clk);
    end
    idle();
    vectors++; if (ctrl_valid !== 1'b1 || opcode !== OP_RTYPE || ctrl !== 8'b1_10_0_0_0_1_0 || elem_idx !== 2'd0 || last_elem !== 1'b1) begin
      miscompares++; $display("FAIL rtype_no_bubble got=%b/%h/%b/%0d/%b exp=1/00/11000010/0/1", ctrl_valid, opcode, ctrl, elem_idx, last_elem); end
    $display("Rtype after LW_V: ctrl=%b", ctrl);
    @(negedge clk);
  endtask

  task automatic test_beq_not_taken();
    offer(OP_BEQ);
    @(negedge clk);
    idle();
    for (int c = 1; c <= 3; c++) begin
      vectors++; if (beq_enable !== 1'b1 || instn_ready !== 1'b0 || flush !== 1'b0) begin miscompares++; $display("FAIL beq_wait%0d got=%b/%b/%b exp=1/0/0", c, beq_enable, instn_ready, flush); end
      vectors++; if (branch !== (c == 1) || ctrl_valid !== (c == 1)) begin miscompares++; $display("FAIL beq_branch%0d got=%b/%b exp=%b", c, branch, ctrl_valid, c == 1); end
      $display("BEQ wait t+%0d: beq_enable=%b branch=%b", c, beq_enable, branch);
      if (c == 3) begin br_resolved = 1'b1; PCSrc = 1'b0; end
      @(negedge clk);
    end
    br_resolved = 1'b0;
    vectors++; if (instn_ready !== 1'b1 || beq_enable !== 1'b0 || flush !== 1'b0) begin miscompares++; $display("FAIL beq_nt_return got=%b/%b/%b exp=1/0/0", instn_ready, beq_enable, flush); end
    $display("BEQ not taken: ready=%b", instn_ready);
  endtask

  task automatic test_beq_taken();
    offer(OP_BEQ);
    br_resolved = 1'b1; PCSrc = 1'b1;   // must be ignored in the accept cycle
    @(negedge clk);
    idle(); br_resolved = 1'b0; PCSrc = 1'b0;
    vectors++; if (beq_enable !== 1'b1 || z_beq_enable !== 1'b1 || flush !== 1'b0) begin miscompares++; $display("FAIL beq_accept_resolve got=%b/%b/%b exp=1/1/0", beq_enable, z_beq_enable, flush); end
    @(negedge clk);
    br_resolved = 1'b1; PCSrc = 1'b1;
    @(negedge clk);
    br_resolved = 1'b0; PCSrc = 1'b0;
    vectors++; if (flush !== 1'b1 || instn_ready !== 1'b0 || beq_enable !== 1'b1) begin miscompares++; $display("FAIL taken_flush1 got=%b/%b/%b exp=1/0/1", flush, instn_ready, beq_enable); end
    vectors++; if (z_flush !== 1'b0 || z_instn_ready !== 1'b1 || z_beq_enable !== 1'b0) begin miscompares++; $display("FAIL taken_noflush got=%b/%b/%b exp=0/1/0", z_flush, z_instn_ready, z_beq_enable); end
    $display("BEQ taken t+3: flush=%b flush0=%b", flush, z_flush);
    @(negedge clk);
    vectors++; if (flush !== 1'b1 || instn_ready !== 1'b0) begin miscompares++; $display("FAIL taken_flush2 got=%b/%b exp=1/0", flush, instn_ready); end
    $display("BEQ taken t+4: flush=%b", flush);
    @(negedge clk);
    vectors++; if (flush !== 1'b0 || instn_ready !== 1'b1 || beq_enable !== 1'b0) begin miscompares++; $display("FAIL taken_return got=%b/%b/%b exp=0/1/0", flush, instn_ready, beq_enable); end
    $display("BEQ taken t+5: ready=%b", instn_ready);
  endtask

  task automatic test_illegal();
    offer(OP_BAD);
    @(negedge clk);
    idle();
    vectors++; if (illegal !== 1'b1 || ctrl_valid !== 1'b1 || ctrl !== 8'h00 || opcode !== OP_BAD) begin miscompares++; $display("FAIL illegal_issue got=%b/%b/%b/%h exp=1/1/00000000/3f", illegal, ctrl_valid, ctrl, opcode); end
    $display("illegal: illegal=%b ctrl=%b", illegal, ctrl);
    @(negedge clk);
    vectors++; if (illegal !== 1'b0) begin miscompares++; $display("FAIL illegal_one_beat got=%b exp=0", illegal); end
  endtask

  task automatic test_reset_mid_vector();
    offer(OP_SW_V);
    @(negedge clk);
    idle();
    vectors++; if (MemWrite !== 1'b1 || elem_idx !== 2'd0) begin miscompares++; $display("FAIL swv_beat0 got=%b/%0d exp=1/0", MemWrite, elem_idx); end
    @(negedge clk);
    vectors++; if (MemWrite !== 1'b1 || elem_idx !== 2'd1) begin miscompares++; $display("FAIL swv_beat1 got=%b/%0d exp=1/1", MemWrite, elem_idx); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++; if (MemWrite !== 1'b0 || ctrl_valid !== 1'b0 || instn_ready !== 1'b1) begin miscompares++; $display("FAIL swv_reset got=%b/%b/%b exp=0/0/1", MemWrite, ctrl_valid, instn_ready); end
    $display("SW_V reset: MemWrite=%b ready=%b", MemWrite, instn_ready);
    @(negedge clk);
    vectors++; if (ctrl_valid !== 1'b0 || elem_idx !== 2'd0) begin miscompares++; $display("FAIL swv_abandon got=%b/%0d exp=0/0", ctrl_valid, elem_idx); end
  endtask

  initial begin
    test_reset();
    test_scalar();
    test_vector();
    test_beq_not_taken();
    test_beq_taken();
    test_illegal();
    test_reset_mid_vector();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vec_issue_controller.md
# vec_issue_controller

Registered instruction-issue controller for the vector processor. It decodes the shared opcode set into datapath control lines and adds sequential behaviour: LW_V/SW_V are issued as VLEN per-element beats with an element index, and BEQ holds issue until the branch resolves, then raises a parametrised flush window if the branch is taken. It sits between instruction fetch, which uses a valid/ready handshake, and the execute/memory/write-back control inputs.

## Interface
- VLEN, 4, elements per vector memory op; legal range ≥1.
- BR_FLUSH, 2, flush cycles after a taken branch; legal range ≥0.
- IW (localparam) = max(1, $clog2(VLEN)), width of elem_idx.
- clk  in  1  clock. One clock domain; all state is updated on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- instn  in  32  instruction; opcode is instn[31:26]; uses the project opcode defines.
- instn_valid  in  1  fetch offers instn.
- instn_ready  out  1  controller accepts this cycle (combinational).
- br_resolved  in  1  branch outcome valid this cycle.
- PCSrc  in  1  branch taken; sampled only when br_resolved=1.
- opcode  out  6  opcode of the issued instruction.
- ctrl_valid  out  1  the control lines below describe a real issue beat.
- RegDst, ALUSrc, branch, MemWrite, RegWrite, MemtoReg  out  1 each  datapath controls.
- ALUOp  out  2  ALU operation class.
- elem_idx  out  IW  element index of the current vector beat; 0 for scalar beats.
- last_elem  out  1  final beat of an instruction (always 1 on scalar beats).
- illegal  out  1  issued opcode is not in the decode list.
- beq_enable  out  1  high in BR_WAIT and FLUSH.
- flush  out  1  fetch/pipeline flush request.

## Operation
- An instruction is accepted when instn_valid && instn_ready. On acceptance, ir<=instn, ctrl_valid<=1, elem_idx<=0. The instruction is issued in the next cycle.
- Decode uses the order RegDst, ALUOp, ALUSrc, branch, MemWrite, RegWrite, MemtoReg:
  - Rtype: 1,10,0,0,0,1,0
  - LW: 0,10,1,0,0,1,1
  - SW: 0,00,1,0,1,0,0
  - LW_R and LW_V: 1,10,0,0,0,1,1
  - SW_R and SW_V: 1,10,0,0,1,0,0
  - BEQ: 0,01,0,1,0,0,0
  - ADDI and SET: 0,00,1,0,0,1,0
  - Any other opcode: all 0 with illegal=1.
- Gating: when ctrl_valid=0, every control output, illegal and last_elem are forced to 0. opcode still reflects ir.
- NORMAL state:
  - instn_ready=1.
  - On accept, the next state is VEC if the opcode is LW_V/SW_V and VLEN>1, BR_WAIT if the opcode is BEQ, and NORMAL otherwise.
  - With no accept, ctrl_valid<=0.
- VEC state:
  - ctrl_valid stays 1 and elem_idx increments by 1 each cycle.
  - instn_ready=1 only when elem_idx==VLEN-1. An accept in that cycle follows the NORMAL accept rules, giving zero-bubble back-to-back issue.
  - Without an accept on the last beat: next state NORMAL, ctrl_valid<=0.
- BR_WAIT state:
  - instn_ready=0 and ctrl_valid<=0; BEQ is issued exactly one beat.
  - br_resolved && !PCSrc → NORMAL.
  - br_resolved && PCSrc → FLUSH with cnt<=BR_FLUSH, or straight to NORMAL if BR_FLUSH==0.
  - No resolution: remain in BR_WAIT indefinitely.
- FLUSH state:
  - instn_ready=0, flush=1, cnt decrements each cycle.
  - Leaves to NORMAL in the cycle cnt==1.
- br_resolved outside BR_WAIT is ignored, including when it arrives in the same cycle as the BEQ accept.
- Reset: state=NORMAL, ir=0, cnt=0, ctrl_valid=0, elem_idx=0. Every output is 0 except instn_ready, which is 1 after reset. A reset mid-vector or mid-flush abandons the operation with no further beats.

## Timing
- Issue latency is 1 cycle from accept to ctrl_valid.
- A vector op occupies VLEN consecutive beats. VLEN==1 behaves as scalar.
- Scalar throughput is 1 instruction per cycle.
- Branch cost is 1 issue beat plus the wait for resolution, plus BR_FLUSH flush cycles if taken.
- flush is high for exactly BR_FLUSH cycles, starting the cycle after the taken resolution.

## Test plan
- Reset held 2 cycles, then released → instn_ready=1; ctrl_valid, flush and RegWrite=0. Then ADDI accepted at t → at t+1: ctrl_valid=1, ALUSrc=1, RegWrite=1, ALUOp=00, last_elem=1.
- VLEN=4: LW_V at t, Rtype offered continuously → beats t+1..t+4 with elem_idx 0,1,2,3, MemtoReg=1; last_elem only at t+4. instn_ready=1 only at t+4. Rtype issued at t+5 with no bubble.
- BEQ at t, br_resolved=1 and PCSrc=0 at t+3 → beq_enable=1 at t+1..t+3; branch=1 only at t+1; instn_ready returns to 1 at t+4; flush never asserted.
- BEQ, taken resolution at t+2 with BR_FLUSH=2 → flush=1 at t+3 and t+4, NORMAL at t+5. Same case with BR_FLUSH=0 → no flush, NORMAL at t+3.
- Opcode 6'b111111 accepted → illegal=1 and all controls 0 for one beat. Separately, rst asserted at elem_idx=1 of SW_V → MemWrite=0 the next cycle and instn_ready=1.
